cla_addsub_pipe: RTL



---
 rtl/cla_pkg.sv | 24 ++
 rtl/cla_group.sv | 40 ++++
 rtl/cla_addsub_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants, stage-count helper and pipeline stage payload for the
// pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GROUP = 4;
  localparam int unsigned CLA_GPS   = 2;
  localparam int unsigned CLA_MAX_W = 64;

  function automatic int unsigned cla_nstage(input int unsigned w, input int unsigned g,
                                             input int unsigned gps);
    return w / (g * gps);
  endfunction

  // Operands travel unshifted; each stage fills its slice of sum and forwards its carry.
  typedef struct packed {
    logic [CLA_MAX_W-1:0] a;
    logic [CLA_MAX_W-1:0] b;
    logic [CLA_MAX_W-1:0] sum;
    logic                 carry;
    logic                 valid;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// GROUP-bit full carry-lookahead block: every carry is a flat sum of
// generate/propagate products, no ripple inside the group.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             pp;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c  = '0;
    pp = 1'b0;
    c[0] = cin;
    for (int i = 0; i < int'(GROUP); i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor: GPS lookahead groups per stage, carry
// registered between stages, valid/ready stream handshake, carry/ovf/zero flags.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP,
  parameter int unsigned GPS   = CLA_GPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW     = GROUP * GPS;
  localparam int unsigned NSTAGE = cla_nstage(WIDTH, GROUP, GPS);

  if (GROUP < 1 || GPS < 1 || (WIDTH % SW) != 0 || WIDTH > CLA_MAX_W) begin : g_bad_cfg
    $fatal(1, "cla_addsub_pipe: WIDTH must be a multiple of GROUP*GPS and fit the stage payload");
  end

  cla_stage_t       stg0;
  cla_stage_t       stg_in [NSTAGE];
  cla_stage_t       stg_d  [NSTAGE];
  cla_stage_t       stg_q  [NSTAGE];
  logic [NSTAGE-1:0] cmsb;
  logic             adv;
  logic [WIDTH-1:0] sum_w;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             unused_bits;

  // Whole pipeline advances only when the output slot is free or being drained.
  assign adv      = ~stg_q[NSTAGE-1].valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    stg0       = '0;
    stg0.a     = CLA_MAX_W'(a);
    stg0.b     = CLA_MAX_W'(b ^ {WIDTH{sub}});
    stg0.carry = cin ^ sub;
    stg0.valid = in_valid;
  end

  for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stage
    localparam int unsigned OFF = k * SW;
    logic [SW-1:0] a_sl, b_sl, s_sl;
    logic [GPS:0]  gc;
    logic [GPS-1:0] gmsb;
    cla_stage_t    d, q;

    if (k == 0) begin : g_first
      assign stg_in[k] = stg0;
    end else begin : g_next
      assign stg_in[k] = stg_q[k-1];
    end

    assign a_sl  = SW'(stg_in[k].a >> OFF);
    assign b_sl  = SW'(stg_in[k].b >> OFF);
    assign gc[0] = stg_in[k].carry;

    // Groups within a stage chain through their lookahead carry-outs.
    for (genvar j = 0; j < int'(GPS); j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a     (a_sl[j*GROUP +: GROUP]),
        .b     (b_sl[j*GROUP +: GROUP]),
        .cin   (gc[j]),
        .s     (s_sl[j*GROUP +: GROUP]),
        .cout  (gc[j+1]),
        .c_msb (gmsb[j])
      );
    end

    always_comb begin
      d       = stg_in[k];
      d.sum   = stg_in[k].sum | (CLA_MAX_W'(s_sl) << OFF);
      d.carry = gc[GPS];
    end

    assign stg_d[k] = d;
    assign cmsb[k]  = gmsb[GPS-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q <= d;
      end
    end

    assign stg_q[k] = q;
  end

  // Flags come from the final stage's carries and completed sum.
  assign sum_w  = WIDTH'(stg_d[NSTAGE-1].sum);
  assign zero_d = ~|sum_w;
  assign ovf_d  = cmsb[NSTAGE-1] ^ stg_d[NSTAGE-1].carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = stg_q[NSTAGE-1].valid;
  assign sum       = WIDTH'(stg_q[NSTAGE-1].sum);
  assign cout      = stg_q[NSTAGE-1].carry;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  assign unused_bits = ^{stg_q[NSTAGE-1].a, stg_q[NSTAGE-1].b, stg_q[NSTAGE-1].sum, cmsb};

endmodule
